// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential binary-to-BCD converter (shift-and-add-3, one input
//            bit per clock) with start/done handshake and overflow flag.
//            bcd_out holds bin_in mod 10^DIGITS; overflow flags bin_in that
//            does not fit in DIGITS decimal digits.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   next_scratch;
  logic               shift_out;

  // Pre-shift correction: a digit of 5..9 becomes 8..12 so that the
  // following doubling carries exactly one ten into the next digit.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign adjusted[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ?
                                  (scratch[4*g +: 4] + 4'd3) :
                                  scratch[4*g +: 4];
    end
  endgenerate

  // One doubling step: next binary bit enters the units digit; the bit
  // leaving the top digit is a carry beyond 10^DIGITS.
  assign next_scratch = {adjusted[BCD_W-2:0], shift_reg[BIN_W-1]};
  assign shift_out    = adjusted[BCD_W-1];

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            carry     <= 1'b0;
            cnt       <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          scratch   <= next_scratch;
          shift_reg <= shift_reg << 1;
          carry     <= carry | shift_out;
          cnt       <= cnt - CNT_W'(1);
          // Last iteration: publish the result straight from the step logic.
          if (cnt == CNT_W'(1)) begin
            bcd_out  <= next_scratch;
            overflow <= carry | shift_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It generalises our fixed 4-bit decimal-to-BCD decoder to any binary width and any number of output digits. It adds a start/done handshake and an overflow flag. It sits between arithmetic/counter datapaths and the 7-segment display drivers.

## Interface
- BIN_W, default 8: width of binary input; legal range 1..32.
- DIGITS, default 3: number of BCD output digits; legal range 1..10.

- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary operand; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/overflow are updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in [4k+3:4k]; held until next done.
- overflow  output  1  high when bin_in ≥ 10^DIGITS; valid with done and held with bcd_out.

## Operation
- States: IDLE, CONV.
- IDLE: busy=0. On an edge with start=1: load shift register with bin_in, clear the BCD scratch register and the sticky carry flag, load the bit counter with BIN_W, and go to CONV.
- CONV: busy=1. Each edge performs one iteration:
  - Every scratch digit ≥5 gets +3.
  - {scratch, shift} shift left one bit.
  - Any bit shifted out of the top digit's MSB sets the sticky carry.
  - The counter decrements.
- On the edge that completes iteration BIN_W:
  - Register the final scratch into bcd_out and the sticky carry into overflow.
  - Pulse done.
  - Return to IDLE.
- Arithmetic rule: bcd_out = bin_in mod 10^DIGITS, encoded in BCD; overflow = (bin_in ≥ 10^DIGITS). With defaults, overflow is never set.
- Every scratch digit is a valid BCD digit (0..9) at all times.
- start while busy=1 is ignored; there is no queueing, and bin_in changes during CONV have no effect.
- Reset values: busy=0, done=0, overflow=0, bcd_out=all zeros, state=IDLE, internal registers cleared.
- Reset asserted mid-conversion aborts immediately: outputs return to reset values, and no done is produced for the aborted operation.

## Timing
- Edge E0 samples start=1. busy is high from after E0 until after E_BIN_W.
- bcd_out, overflow and done=1 are visible after edge E_BIN_W. Latency is BIN_W cycles from the accepting edge.
- done is high for exactly one cycle, the first IDLE cycle. busy=0 in that cycle.
- A start asserted in the done cycle is accepted at the next edge. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- bcd_out and overflow change only on the done edge or at reset; they are stable otherwise.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults (BIN_W=8, DIGITS=3), bin_in=255, start for 1 cycle -> exactly 8 cycles later done=1 for 1 cycle, bcd_out=12'h255, overflow=0, busy high for 8 cycles.
- Defaults, bin_in=0 then bin_in=99 -> bcd_out=12'h000, then 12'h099; overflow=0 both times.
- DIGITS=2, BIN_W=8, bin_in=255 -> bcd_out=8'h55, overflow=1. Then bin_in=100 -> 8'h00, overflow=1. Then 99 -> 8'h99, overflow=0.
- Start held high continuously with bin_in changing during CONV, defaults -> one result per 9 cycles. Each result equals the value sampled at its accepting edge. bin_in changes mid-conversion are ignored.
- rst_n pulled low at cycle 4 of a conversion of 200 -> busy, done, overflow and bcd_out go to 0 immediately. No done follows. A fresh start with 37 then yields 12'h037.
- Exhaustive sweep: BIN_W=10, DIGITS=3, all inputs 0..1023 -> bcd_out equals a reference model of value mod 1000, and overflow=1 exactly for inputs ≥1000.
